gray_enc: RTL and testbench



---
 rtl/gray_pkg.sv | 35 +++
 rtl/gray_enc_step_chk.sv | 24 ++
 rtl/gray_enc.sv | 63 ++++++
 tb/tb_gray_enc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared helpers for the Gray encoder slice.
//   bin2gray  - binary to reflected Gray (operates on up to 32 bits, zero-extended)
//   gray2bin  - reflected Gray back to binary (prefix XOR from the MSB down)
//   popcount  - number of set bits in a 32-bit word
//   GRAY_WIDTH - default code width
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  // Zero-extended inputs keep these functions width-agnostic: extra upper
  // zeros encode and decode to zeros.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_enc_step_chk.sv
// gray_step_chk: next-state for the step-error flag.
//   i_prev            - previously captured Gray code
//   i_new             - Gray code being captured now
//   i_valid           - a previous capture exists
//   o_step_err_next   - high when the Hamming distance is not exactly one
module gray_step_chk
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_new,
  input  logic             i_valid,
  output logic             o_step_err_next
);

  logic [5:0] w_dist;

  assign w_dist = popcount(32'(i_prev ^ i_new));

  // The first capture after reset has nothing to compare against.
  assign o_step_err_next = i_valid && (w_dist != 6'd1);

endmodule

// File: rtl/gray_enc.sv
// gray_enc: binary-to-Gray encoder with a registered, step-checked output.
//   clock     - rising-edge clock for the capture stage
//   reset_n   - asynchronous active-low reset
//   Nbin      - binary input
//   en        - capture strobe
//   Ngray     - combinational Gray code of Nbin
//   Ngray_q   - Gray code of the last captured Nbin
//   valid_q   - at least one capture since reset
//   Nbin_dec  - binary decode of Ngray_q
//   step_err  - one-cycle pulse when a capture moves by other than one bit
module gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] Nbin,
  input  logic             en,
  output logic [WIDTH-1:0] Ngray,
  output logic [WIDTH-1:0] Ngray_q,
  output logic             valid_q,
  output logic [WIDTH-1:0] Nbin_dec,
  output logic             step_err
);

  logic [WIDTH-1:0] r_gray_q;
  logic             r_valid_q;
  logic             r_step_err;
  logic             w_step_err_next;

  assign Ngray = WIDTH'(bin2gray(32'(Nbin)));

  gray_step_chk #(
    .WIDTH(WIDTH)
  ) u_step_chk (
    .i_prev          (r_gray_q),
    .i_new           (Ngray),
    .i_valid         (r_valid_q),
    .o_step_err_next (w_step_err_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gray_q   <= '0;
      r_valid_q  <= 1'b0;
      r_step_err <= 1'b0;
    end else if (en) begin
      r_gray_q   <= Ngray;
      r_valid_q  <= 1'b1;
      r_step_err <= w_step_err_next;
    end else begin
      // Error is a pulse tied to a capture; idle edges clear it.
      r_step_err <= 1'b0;
    end
  end

  assign Ngray_q  = r_gray_q;
  assign valid_q  = r_valid_q;
  assign step_err = r_step_err;
  assign Nbin_dec = WIDTH'(gray2bin(32'(r_gray_q)));

endmodule

// File: tb/tb_gray_enc.sv
module tb_gray_enc;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
  } vec_t;

  typedef struct {
    logic [3:0] gray_q;
    logic [3:0] dec;
    logic       valid;
    logic       err;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic [3:0] nbin4;
  logic       en4;
  logic [3:0] ngray4, ngray_q4, dec4;
  logic       valid4, err4;
  logic [7:0] nbin8;
  logic       en8;
  logic [7:0] ngray8, ngray_q8, dec8;
  logic       valid8, err8;

  int n_checks = 0;
  int n_errors = 0;

  vec_t tbl[16];
  exp_t sb[$];

  // reference model state for the 4-bit DUT
  logic [3:0] m_gray;
  logic [3:0] m_bin;
  logic       m_valid;

  gray_enc #(.WIDTH(4)) dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .Nbin     (nbin4),
    .en       (en4),
    .Ngray    (ngray4),
    .Ngray_q  (ngray_q4),
    .valid_q  (valid4),
    .Nbin_dec (dec4),
    .step_err (err4)
  );

  gray_enc #(.WIDTH(8)) dut8 (
    .clock    (clock),
    .reset_n  (reset_n),
    .Nbin     (nbin8),
    .en       (en8),
    .Ngray    (ngray8),
    .Ngray_q  (ngray_q8),
    .valid_q  (valid8),
    .Nbin_dec (dec8),
    .step_err (err8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the 4-bit DUT, push the model's expectation, and
  // compare after the edge.
  task automatic step4(input logic [3:0] v, input logic e, input string name);
    exp_t x;
    @(negedge clock);
    nbin4 = v;
    en4   = e;
    if (e) begin
      x.err   = m_valid && ($countones(tbl[v].gray ^ m_gray) != 1);
      m_gray  = tbl[v].gray;
      m_bin   = v;
      m_valid = 1'b1;
    end else begin
      x.err = 1'b0;
    end
    x.gray_q = m_gray;
    x.dec    = m_bin;
    x.valid  = m_valid;
    sb.push_back(x);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk({name, "_gray_q"}, 32'(ngray_q4), 32'(x.gray_q));
      chk({name, "_dec"},    32'(dec4),     32'(x.dec));
      chk({name, "_valid"},  32'(valid4),   32'(x.valid));
      chk({name, "_err"},    32'(err4),     32'(x.err));
    end
  endtask

  initial begin
    tbl[0]  = '{4'd0,  4'b0000}; tbl[1]  = '{4'd1,  4'b0001};
    tbl[2]  = '{4'd2,  4'b0011}; tbl[3]  = '{4'd3,  4'b0010};
    tbl[4]  = '{4'd4,  4'b0110}; tbl[5]  = '{4'd5,  4'b0111};
    tbl[6]  = '{4'd6,  4'b0101}; tbl[7]  = '{4'd7,  4'b0100};
    tbl[8]  = '{4'd8,  4'b1100}; tbl[9]  = '{4'd9,  4'b1101};
    tbl[10] = '{4'd10, 4'b1111}; tbl[11] = '{4'd11, 4'b1110};
    tbl[12] = '{4'd12, 4'b1010}; tbl[13] = '{4'd13, 4'b1011};
    tbl[14] = '{4'd14, 4'b1001}; tbl[15] = '{4'd15, 4'b1000};

    m_gray = '0; m_bin = '0; m_valid = 1'b0;
    reset_n = 1'b0;
    nbin4 = 4'd0; en4 = 1'b0;
    nbin8 = 8'd0; en8 = 1'b0;
    #2;
    chk("rst_gray_q", 32'(ngray_q4), 32'd0);
    chk("rst_valid",  32'(valid4),   32'd0);
    chk("rst_err",    32'(err4),     32'd0);
    chk("rst_dec",    32'(dec4),     32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // combinational sweep, no captures
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      nbin4 = tbl[i].bin;
      en4   = 1'b0;
      #1;
      chk($sformatf("sweep_gray_%0d", i), 32'(ngray4), 32'(tbl[i].gray));
      chk($sformatf("sweep_q_%0d", i), 32'(ngray_q4), 32'd0);
    end

    // counting captures 0..15 then wrap to 0
    for (int i = 0; i < 16; i++) begin
      step4(4'(i), 1'b1, $sformatf("cnt%0d", i));
    end
    step4(4'd0, 1'b1, "wrap");
    chk("wrap_err_zero", 32'(err4), 32'd0);

    // distance-2 step
    step4(4'd3, 1'b1, "d2_a");
    step4(4'd5, 1'b1, "d2_b");
    chk("d2_err_one", 32'(err4), 32'd1);
    step4(4'd5, 1'b0, "d2_idle");

    // repeated value
    step4(4'd6, 1'b1, "rep_a");
    step4(4'd6, 1'b1, "rep_b");
    chk("rep_err_one", 32'(err4), 32'd1);
    step4(4'd1, 1'b0, "rep_idle");
    chk("rep_hold_q", 32'(ngray_q4), 32'b0101);
    chk("rep_idle_err", 32'(err4), 32'd0);

    // asynchronous reset mid-stream
    step4(4'd9, 1'b1, "pre_rst");
    @(negedge clock);
    en4 = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_gray_q", 32'(ngray_q4), 32'd0);
    chk("arst_valid",  32'(valid4),   32'd0);
    chk("arst_err",    32'(err4),     32'd0);
    chk("arst_dec",    32'(dec4),     32'd0);
    nbin4 = 4'd7;
    #1;
    chk("arst_track", 32'(ngray4), 32'b0100);
    m_gray = '0; m_bin = '0; m_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step4(4'd12, 1'b1, "post_rst");
    chk("post_rst_q", 32'(ngray_q4), 32'b1010);

    // 8-bit instance
    @(negedge clock);
    nbin8 = 8'hFF;
    #1;
    chk("w8_ff", 32'(ngray8), 32'h80);
    nbin8 = 8'hA5;
    #1;
    chk("w8_a5", 32'(ngray8), 32'hF7);
    en8 = 1'b1;
    @(posedge clock);
    #1;
    en8 = 1'b0;
    chk("w8_q",     32'(ngray_q8), 32'hF7);
    chk("w8_dec",   32'(dec8),     32'hA5);
    chk("w8_valid", 32'(valid8),   32'd1);
    chk("w8_err",   32'(err8),     32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
